portb_arbiter: RTL
==================

Name: portb_arbiter

Overview:
- Shares the single CPU data port (RAM/device port B) between the CPU and one DMA-style bus master, such as a VGA fetcher or comm-channel engine.
- Sits between the CPU's port-B signals and the memory-mapped device bus (socram plus devices).
- Drives the CPU's stall input.
- Enforces bounded DMA bursts and bounded DMA starvation.

Parameters:
- MAX_BURST, 8: max consecutive DMA beats granted while cpu_req is pending (DMA_PRIO=1 only); range 1..255.
- STARVE_LIMIT, 16: cycles a pending DMA request may be denied before a forced DMA beat (DMA_PRIO=0 only); range 1..255.
- DMA_PRIO, 0: 0 = CPU wins contention; 1 = DMA wins contention.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU port-B access this cycle
- cpu_addr  in  32  CPU address
- cpu_wdata  in  32  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_rdata  out  32  read data to CPU
- stall_cpu  out  1  CPU must hold request
- dma_req  in  1  DMA access request
- dma_addr  in  32  DMA address
- dma_wdata  in  32  DMA write data
- dma_we  in  1  DMA write enable
- dma_gnt  out  1  DMA beat accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  32  DMA read data
- bus_addr  out  32  device bus address
- bus_wdata  out  32  device bus write data
- bus_we  out  1  device bus write enable
- bus_rdata  in  32  device bus read data (muxed device strobes), valid 1 cycle after address
- stats_data  out  32  statistics read data (see Optional Feature)
- stats_strobe  out  1  stats own current bus address

Behaviour:
- Grant decision is combinational per cycle from requests and registered counters.
- Exactly one of cpu_gnt/dma_gnt is high, or neither.
- Grant rules:
  - No requests: no grant; bus_addr=cpu_addr, bus_we=0.
  - Only cpu_req: CPU granted.
  - Only dma_req: DMA granted.
  - Both, DMA_PRIO=0: DMA granted iff starve_cnt == STARVE_LIMIT-1; else CPU.
  - Both, DMA_PRIO=1: CPU granted iff burst_cnt == MAX_BURST; else DMA.
- Outputs:
  - stall_cpu = cpu_req & ~cpu_gnt.
  - dma_gnt = DMA granted.
  - Bus signals come from the granted master; bus_we is forced 0 when there is no grant.
  - A stalled CPU write never reaches the bus.
- Counters (8-bit, registered):
  - burst_cnt increments on a DMA grant while cpu_req=1.
  - burst_cnt clears on a CPU grant or when cpu_req=0.
  - burst_cnt saturates at MAX_BURST.
  - starve_cnt increments when dma_req & ~dma_gnt.
  - starve_cnt clears on dma_gnt or dma_req=0.
  - starve_cnt saturates at STARVE_LIMIT-1.
- Read return:
  - dma_rvalid is registered: high the cycle after dma_gnt & ~dma_we, single cycle.
  - dma_rdata = bus_rdata.
  - cpu_rdata = bus_rdata; the CPU samples it the cycle after its own granted read.
  - Back-to-back grants alternating masters return data in grant order, 1 cycle each; no buffering.
- DMA handshake: the master keeps addr/we/wdata stable while dma_req=1 and dma_gnt=0, and may change them the cycle after dma_gnt.
- Reset (rst=0, asynchronous):
  - Counters, dma_rvalid, and the rvalid pipeline flop clear immediately.
  - Grants are forced 0; bus_we=0; stall_cpu=0.
  - A read in flight when reset asserts never produces dma_rvalid.
- Writes to the same address by both masters are serialized by the grant; there is no merging.

Optional Feature:
ARB_STATS_EN
- Defined: adds two 32-bit wrapping counters.
  - stall_cycles: +1 per cycle with stall_cpu=1.
  - dma_beats: +1 per dma_gnt.
- Memory-mapped on the bus output side:
  - stats_strobe=1 when bus_addr is 65543 or 65544 and the access is not a write.
  - stats_data returns stall_cycles or dma_beats respectively.
- A granted write to 65543 clears both counters that cycle; the clear takes precedence over a same-cycle increment.
- Reset clears both counters.
- Undefined: stats_data=0 and stats_strobe=0 constantly; no counter flops.

Test Plan:
1. CPU-only stream: cpu_req=1, 10 reads of addr 0..9 → stall_cpu=0 throughout; bus_addr tracks cpu_addr; cpu_rdata = RAM[n] one cycle later.
2. DMA_PRIO=0, STARVE_LIMIT=4, cpu_req and dma_req held high → grant pattern C,C,C,D repeating; stall_cpu=1 only on the D cycles; dma_rvalid 1 cycle after each D read.
3. DMA_PRIO=1, MAX_BURST=8, both held high → 8 DMA grants, 1 CPU grant, repeat; stall_cpu=1 for exactly 8 of every 9 cycles.
4. Simultaneous CPU write 0xAAAA0000 and DMA write 0x5555 to addr 100, DMA_PRIO=0, STARVE_LIMIT=16 → CPU write first, DMA write next cycle; a read of 100 returns 0x5555.
5. rst pulled low the cycle after a DMA read grant → dma_rvalid stays 0; after release, counters are 0 and the first contention cycle grants CPU.
6. With ARB_STATS_EN, 5 forced stall cycles then a CPU read of 65543 → stats_strobe=1, value 5; a CPU write to 65543 then a read of 65544 → 0.

Source files
------------

// File: rtl/portb_arbiter.sv
// portb_arbiter: shares the CPU data port (port B) between the CPU and one
// DMA-style bus master. It decides the grant combinationally each cycle,
// keeps DMA bursts and DMA starvation bounded, and drives the CPU stall.
// Optional build macro: ARB_STATS_EN adds stall/DMA-beat statistics
// counters that are readable at bus addresses 65543 and 65544.
module portb_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int DMA_PRIO     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic        stall_cpu,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_we,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic [31:0] bus_rdata,
  output logic [31:0] stats_data,
  output logic        stats_strobe
);

  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT - 1);

  logic [7:0] burst_cnt;
  logic [7:0] starve_cnt;
  logic       cpu_gnt;
  logic       vld_p1;

  // Saturating increment for the arbitration counters.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] lim);
    return (cnt >= lim) ? lim : cnt + 8'd1;
  endfunction

  // Grant decision: uncontended requests win outright; on contention the
  // priority master wins unless its bound (burst or starvation) is reached.
  // All grants are forced off while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst) begin
      if (cpu_req && dma_req) begin
        if (DMA_PRIO != 0) begin
          if (burst_cnt == BURST_MAX) cpu_gnt = 1'b1;
          else                        dma_gnt = 1'b1;
        end else begin
          if (starve_cnt == STARVE_MAX) dma_gnt = 1'b1;
          else                          cpu_gnt = 1'b1;
        end
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  // Bus mux: the granted master drives the bus; with no grant the CPU
  // address is presented and no write occurs, so a stalled write is dropped.
  always_comb begin
    bus_addr  = dma_gnt ? dma_addr  : cpu_addr;
    bus_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    bus_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
    stall_cpu = rst & cpu_req & ~cpu_gnt;
    cpu_rdata = bus_rdata;
    dma_rdata = bus_rdata;
    dma_rvalid = vld_p1;
  end

  // Stage p0 -> p1: burst/starvation counters and the DMA read-return flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt  <= 8'd0;
      starve_cnt <= 8'd0;
      vld_p1     <= 1'b0;
    end else begin
      if (!cpu_req || cpu_gnt) burst_cnt <= 8'd0;
      else if (dma_gnt)        burst_cnt <= sat_inc(burst_cnt, BURST_MAX);
      if (!dma_req || dma_gnt) starve_cnt <= 8'd0;
      else                     starve_cnt <= sat_inc(starve_cnt, STARVE_MAX);
      vld_p1 <= dma_gnt & ~dma_we;
    end
  end

`ifdef ARB_STATS_EN
  localparam logic [31:0] ADDR_STALL = 32'd65543;
  localparam logic [31:0] ADDR_BEATS = 32'd65544;

  logic [31:0] stall_cycles;
  logic [31:0] dma_beats;
  logic        stats_clr;

  assign stats_clr = bus_we && (bus_addr == ADDR_STALL);

  // Statistics counters; a granted write to the stall address clears both
  // and wins over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
      dma_beats    <= 32'd0;
    end else if (stats_clr) begin
      stall_cycles <= 32'd0;
      dma_beats    <= 32'd0;
    end else begin
      if (stall_cpu) stall_cycles <= stall_cycles + 32'd1;
      if (dma_gnt)   dma_beats    <= dma_beats + 32'd1;
    end
  end

  // Statistics read decode on the bus side; writes never strobe.
  always_comb begin
    stats_strobe = !bus_we && ((bus_addr == ADDR_STALL) || (bus_addr == ADDR_BEATS));
    stats_data   = 32'd0;
    if (bus_addr == ADDR_STALL)      stats_data = stall_cycles;
    else if (bus_addr == ADDR_BEATS) stats_data = dma_beats;
  end
`else
  assign stats_data   = 32'd0;
  assign stats_strobe = 1'b0;
`endif

endmodule
